// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding, ALU opcode values and the default register-address width.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } ctrl_state_t;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b110;

  localparam int REG_AW_DEF = 4;

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Combinational load-use detector.
// Flags a decode instruction that reads the destination of a load currently in execute.
module hazard_detect #(
  parameter int REG_AW = 4
) (
  input  logic              valid_execute,
  input  logic              mem_read_execute,
  input  logic [REG_AW-1:0] rd_execute,
  input  logic [REG_AW-1:0] rs_a_decode,
  input  logic [REG_AW-1:0] rs_b_decode,
  input  logic              use_a_decode,
  input  logic              use_b_decode,
  output logic              load_use
);

  logic match_a;
  logic match_b;

  always_comb begin
    match_a  = use_a_decode && (rs_a_decode == rd_execute);
    match_b  = use_b_decode && (rs_b_decode == rd_execute);
    // A bubble in execute never produces a hazard, even with stale load fields.
    load_use = valid_execute && mem_read_execute && (match_a || match_b);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer around the execute stage: load-use stalls, taken-branch flushes
// and multi-cycle ALU holds, plus a saturating count of stalled cycles.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int         MULTI_LAT = 4,
  parameter logic [2:0] MULTI_OP  = ALU_MUL,
  parameter int         REG_AW    = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_a_decode,
  input  logic [REG_AW-1:0] rs_b_decode,
  input  logic              use_a_decode,
  input  logic              use_b_decode,
  input  logic              valid_execute,
  input  logic [REG_AW-1:0] rd_execute,
  input  logic              mem_read_execute,
  input  logic [2:0]        ALUop_execute,
  input  logic              branch_taken_execute,
  output logic              pc_en,
  output logic              fd_en,
  output logic              fd_flush,
  output logic              de_en,
  output logic              de_flush,
  output logic              em_en,
  output logic              em_flush,
  output logic              alu_busy,
  output logic [15:0]       stall_cycles
);

  localparam int              CNT_W    = (MULTI_LAT > 2) ? $clog2(MULTI_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MULTI_LAT >= 2) ? (MULTI_LAT - 2) : 0);
  localparam logic            MULTI_EN = (MULTI_LAT > 1);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      stall_q, stall_d;

  logic load_use;
  logic branch_hit;
  logic multi_hit;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard_detect (
    .valid_execute   (valid_execute),
    .mem_read_execute(mem_read_execute),
    .rd_execute      (rd_execute),
    .rs_a_decode     (rs_a_decode),
    .rs_b_decode     (rs_b_decode),
    .use_a_decode    (use_a_decode),
    .use_b_decode    (use_b_decode),
    .load_use        (load_use)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_en      = 1'b1;
    fd_en      = 1'b1;
    fd_flush   = 1'b0;
    de_en      = 1'b1;
    de_flush   = 1'b0;
    em_en      = 1'b1;
    em_flush   = 1'b0;
    alu_busy   = 1'b0;
    branch_hit = valid_execute && branch_taken_execute;
    multi_hit  = MULTI_EN && valid_execute && (ALUop_execute == MULTI_OP);

    case (state_q)
      RUN: begin
        if (branch_hit) begin
          fd_flush = 1'b1;
          de_flush = 1'b1;
        end else if (multi_hit) begin
          pc_en    = 1'b0;
          fd_en    = 1'b0;
          de_en    = 1'b0;
          em_flush = 1'b1;
          alu_busy = 1'b1;
          state_d  = MULTI;
          cnt_d    = CNT_LOAD;
        end else if (load_use) begin
          pc_en    = 1'b0;
          fd_en    = 1'b0;
          de_flush = 1'b1;
        end
      end
      MULTI: begin
        // Final cycle of the op falls through with defaults so its result lands in ExecuteMemory.
        if (cnt_q != '0) begin
          pc_en    = 1'b0;
          fd_en    = 1'b0;
          de_en    = 1'b0;
          em_flush = 1'b1;
          alu_busy = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (rst) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_en    = 1'b0;
      em_en    = 1'b0;
      fd_flush = 1'b1;
      de_flush = 1'b1;
      em_flush = 1'b1;
      alu_busy = 1'b0;
    end

    stall_d = (!pc_en && (stall_q != 16'hFFFF)) ? (stall_q + 16'd1) : stall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed sequences, a vector table and randomized traffic
// compared against a cycle-level reference model of the hazard rules.
module tb_pipeline_hazard_controller;
  import pipeline_ctrl_pkg::*;

  localparam int LAT = 4;
  // Control vector order: {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, alu_busy}
  localparam logic [7:0] C_RUN   = 8'hD4;
  localparam logic [7:0] C_BR    = 8'hFC;
  localparam logic [7:0] C_LU    = 8'h1C;
  localparam logic [7:0] C_HOLD  = 8'h07;
  localparam logic [7:0] C_RESET = 8'h2A;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rs_a, rs_b, rd;
  logic       use_a, use_b, valid, mem_read, branch;
  logic [2:0] aluop;

  logic       pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, alu_busy;
  logic [15:0] stall_cycles;
  logic       pc_en1, fd_en1, fd_flush1, de_en1, de_flush1, em_en1, em_flush1, alu_busy1;
  logic [15:0] stall_cycles1;

  int checks = 0;
  int errors = 0;

  // Reference model state: execute cycle index of the current multi-cycle op (0 = none).
  int          m_k = 0;
  logic [15:0] m_stall = '0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MULTI_LAT(LAT), .MULTI_OP(3'b110), .REG_AW(4)) u_dut (
    .clk(clk), .rst(rst), .rs_a_decode(rs_a), .rs_b_decode(rs_b),
    .use_a_decode(use_a), .use_b_decode(use_b), .valid_execute(valid),
    .rd_execute(rd), .mem_read_execute(mem_read), .ALUop_execute(aluop),
    .branch_taken_execute(branch), .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush),
    .de_en(de_en), .de_flush(de_flush), .em_en(em_en), .em_flush(em_flush),
    .alu_busy(alu_busy), .stall_cycles(stall_cycles));

  pipeline_hazard_controller #(.MULTI_LAT(1), .MULTI_OP(3'b110), .REG_AW(4)) u_dut1 (
    .clk(clk), .rst(rst), .rs_a_decode(rs_a), .rs_b_decode(rs_b),
    .use_a_decode(use_a), .use_b_decode(use_b), .valid_execute(valid),
    .rd_execute(rd), .mem_read_execute(mem_read), .ALUop_execute(aluop),
    .branch_taken_execute(branch), .pc_en(pc_en1), .fd_en(fd_en1), .fd_flush(fd_flush1),
    .de_en(de_en1), .de_flush(de_flush1), .em_en(em_en1), .em_flush(em_flush1),
    .alu_busy(alu_busy1), .stall_cycles(stall_cycles1));

  typedef struct {
    logic       valid;
    logic [3:0] rs_a;
    logic [3:0] rs_b;
    logic       use_a;
    logic       use_b;
    logic [3:0] rd;
    logic       mem_read;
    logic [2:0] aluop;
    logic       branch;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [7:0] ctrl0();
    return {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, alu_busy};
  endfunction

  function automatic logic [7:0] ctrl1();
    return {pc_en1, fd_en1, fd_flush1, de_en1, de_flush1, em_en1, em_flush1, alu_busy1};
  endfunction

  function automatic logic model_lu();
    return valid && mem_read && ((use_a && rs_a == rd) || (use_b && rs_b == rd));
  endfunction

  function automatic logic [7:0] model_ctrl();
    if (rst) return C_RESET;
    if (m_k > 0) return (m_k < LAT) ? C_HOLD : C_RUN;
    if (valid && branch) return C_BR;
    if (valid && aluop == 3'b110 && LAT > 1) return C_HOLD;
    if (model_lu()) return C_LU;
    return C_RUN;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic ua, input logic ub, input logic [3:0] d,
                        input logic mr, input logic [2:0] op, input logic br);
    valid = v; rs_a = a; rs_b = b; use_a = ua; use_b = ub;
    rd = d; mem_read = mr; aluop = op; branch = br;
  endtask

  // One pipeline cycle: inputs already applied just after the previous edge.
  task automatic do_cycle(input string name, input bit use_exp, input logic [7:0] exp_in,
                          input bit verbose);
    logic [7:0] mexp;
    logic [7:0] exp;
    #2;
    if (rst) begin
      m_k = 0;
      m_stall = '0;
    end
    mexp = model_ctrl();
    exp  = use_exp ? exp_in : mexp;
    check8({name, "_ctrl"}, ctrl0(), exp);
    check16({name, "_stall"}, stall_cycles, m_stall);
    if (verbose)
      $display("txn %-12s rst=%b v=%b mr=%b op=%b br=%b ctrl=%h stall=%0d",
               name, rst, valid, mem_read, aluop, branch, ctrl0(), stall_cycles);
    @(posedge clk);
    if (rst) begin
      m_k = 0;
      m_stall = '0;
    end else begin
      if (!mexp[7] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (m_k > 0) m_k = (m_k < LAT) ? m_k + 1 : 0;
      else if (!(valid && branch) && valid && aluop == 3'b110 && LAT > 1) m_k = 2;
    end
    #1;
  endtask

  initial begin
    logic [15:0] s0;
    rst = 1'b1;
    set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, ALU_ADD, 1'b0);

    vecs[0]  = '{1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b0, ALU_ADD, 1'b0, C_RUN, "default"};
    vecs[1]  = '{1'b1, 4'd3, 4'd2, 1'b1, 1'b0, 4'd3, 1'b1, ALU_ADD, 1'b0, C_LU,  "lu_a"};
    vecs[2]  = '{1'b1, 4'd2, 4'd7, 1'b1, 1'b1, 4'd7, 1'b1, ALU_SUB, 1'b0, C_LU,  "lu_b"};
    vecs[3]  = '{1'b1, 4'd4, 4'd1, 1'b0, 1'b1, 4'd4, 1'b1, ALU_ADD, 1'b0, C_RUN, "no_use_a"};
    vecs[4]  = '{1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd9, 1'b1, ALU_ADD, 1'b0, C_RUN, "ld_nomatch"};
    vecs[5]  = '{1'b0, 4'd6, 4'd6, 1'b1, 1'b1, 4'd6, 1'b1, ALU_ADD, 1'b0, C_RUN, "bubble_ld"};
    vecs[6]  = '{1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, ALU_ADD, 1'b1, C_BR,  "br_lu"};
    vecs[7]  = '{1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b0, ALU_MUL, 1'b1, C_BR,  "br_multi"};
    vecs[8]  = '{1'b0, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b0, ALU_MUL, 1'b0, C_RUN, "bubble_mul"};
    vecs[9]  = '{1'b0, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b0, ALU_ADD, 1'b1, C_RUN, "bubble_br"};
    vecs[10] = '{1'b1, 4'd8, 4'd2, 1'b1, 1'b1, 4'd8, 1'b0, ALU_OR,  1'b0, C_RUN, "alu_match"};

    // Reset held, then released into RUN.
    do_cycle("reset", 1'b1, C_RESET, 1'b1);
    rst = 1'b0;
    do_cycle("post_reset", 1'b1, C_RUN, 1'b1);

    // Single-cycle load-use bubble.
    s0 = stall_cycles;
    set_in(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, ALU_ADD, 1'b0);
    do_cycle("lu_stall", 1'b1, C_LU, 1'b1);
    set_in(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b0, ALU_ADD, 1'b0);
    do_cycle("lu_clear", 1'b1, C_RUN, 1'b1);
    check16("lu_count", stall_cycles - s0, 16'd1);

    // Multi-cycle op: three held cycles, release on the fourth.
    s0 = stall_cycles;
    set_in(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b0, ALU_MUL, 1'b0);
    do_cycle("mul_entry", 1'b1, C_HOLD, 1'b1);
    set_in(1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, ALU_MUL, 1'b1);
    do_cycle("mul_hold1", 1'b1, C_HOLD, 1'b1);
    do_cycle("mul_hold2", 1'b1, C_HOLD, 1'b1);
    do_cycle("mul_release", 1'b1, C_RUN, 1'b1);
    check16("mul_count", stall_cycles - s0, 16'd3);
    set_in(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b0, ALU_ADD, 1'b0);
    do_cycle("mul_after", 1'b1, C_RUN, 1'b1);

    // Reset while the op is held with one cycle left.
    set_in(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b0, ALU_MUL, 1'b0);
    do_cycle("rm_entry", 1'b1, C_HOLD, 1'b1);
    set_in(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b0, ALU_ADD, 1'b0);
    do_cycle("rm_cnt2", 1'b1, C_HOLD, 1'b1);
    rst = 1'b1;
    do_cycle("rm_reset", 1'b1, C_RESET, 1'b1);
    rst = 1'b0;
    do_cycle("rm_resume", 1'b1, C_RUN, 1'b1);
    do_cycle("rm_resume2", 1'b1, C_RUN, 1'b1);

    // Single-latency configuration never holds on the multi opcode.
    set_in(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b0, ALU_MUL, 1'b0);
    #2;
    check8("lat1_mul", ctrl1(), C_RUN);
    #1;
    set_in(1'b1, 4'd5, 4'd2, 1'b1, 1'b1, 4'd5, 1'b1, ALU_MUL, 1'b0);
    #1;
    check8("lat1_mul_lu", ctrl1(), C_LU);
    $display("txn lat1       ctrl1=%h", ctrl1());
    set_in(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b0, ALU_ADD, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].valid, vecs[i].rs_a, vecs[i].rs_b, vecs[i].use_a, vecs[i].use_b,
             vecs[i].rd, vecs[i].mem_read, vecs[i].aluop, vecs[i].branch);
      do_cycle(vecs[i].name, 1'b1, vecs[i].exp, 1'b1);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_in(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0), 3'($urandom), ($urandom_range(0, 7) == 0));
      do_cycle("random", 1'b0, 8'h00, 1'b0);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
